// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// parser_pkg: shared types and helpers for seq_stream_parser.     Rev 1.0
// ============================================================================
package parser_pkg;

  localparam int HDR_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR2 = 2'd1,
    DATA = 2'd2
  } rx_state_t;

  // Link words carry little-endian fields; this restores numeric order.
  function automatic logic [31:0] byteSwap(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/parser_out_fifo.sv
`default_nettype none
// ============================================================================
// parser_out_fifo: synchronous FIFO of completed packet entries.   Rev 1.0
// ============================================================================
module parser_out_fifo #(
  parameter type ENTRY_T    = logic,
  parameter int  FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset_b,
  input  logic   push,
  input  ENTRY_T pushData,
  input  logic   pop,
  output ENTRY_T head,
  output logic   full,
  output logic   empty
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  ENTRY_T               r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [c_PTR_W:0]     r_count;
  logic                 w_doPush;
  logic                 w_doPop;

  assign w_doPush = push & ~full;
  assign w_doPop  = pop & ~empty;
  assign full     = (r_count == (c_PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (r_count == '0);
  assign head     = r_mem[r_rdPtr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

endmodule
`default_nettype wire

// File: rtl/seq_stream_parser.sv
`default_nettype none
// ============================================================================
// seq_stream_parser: length-prefixed packet reassembly with per-stream
// sequence check. Define PARSER_STATS_EN for stat_* counters.      Rev 1.0
// ============================================================================
module seq_stream_parser
  import parser_pkg::*;
#(
  parameter int NUM_STREAMS = 32,
  parameter int MAX_PAYLOAD = 37,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic [31:0]                      dataIn,
  input  logic                             dataIn_val,
  output logic                             dataIn_ready,
  input  logic                             dataIN_last,
  output logic [0:8*MAX_PAYLOAD-1]         dataOut,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] dataOut_bytes,
  output logic [15:0]                      dataOut_stream,
  output logic [31:0]                      dataOut_gap,
  output logic                             packetLost,
  output logic                             badLength,
  output logic                             dataOut_val,
`ifdef PARSER_STATS_EN
  output logic [31:0]                      stat_pkts,
  output logic [31:0]                      stat_lost,
  output logic [31:0]                      stat_bad,
`endif
  input  logic                             dataOut_ready
);

  localparam int          c_BYTES_W = $clog2(MAX_PAYLOAD + 1);
  localparam int          c_SID_W   = $clog2(NUM_STREAMS);
  localparam logic [15:0] c_MIN_LEN = 16'(HDR_BYTES + 1);
  localparam logic [15:0] c_MAX_LEN = 16'(HDR_BYTES + MAX_PAYLOAD);

  typedef struct packed {
    logic [0:8*MAX_PAYLOAD-1] payload;
    logic [c_BYTES_W-1:0]     bytes;
    logic [15:0]              stream;
    logic [31:0]              gap;
    logic                     lost;
    logic                     bad;
  } pkt_entry_t;

  rx_state_t                r_state;
  rx_state_t                w_nextState;
  logic [15:0]              r_len;
  logic [15:0]              r_sid;
  logic [31:0]              r_seq;
  logic [13:0]              r_wordIdx;
  logic [0:8*MAX_PAYLOAD-1] r_payload;
  logic [0:8*MAX_PAYLOAD-1] w_merged;
  logic [31:0]              r_seqTable [NUM_STREAMS];
  logic                     r_readyEn;

  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_bad;
  logic                     w_lenOk;
  logic                     w_sidOk;
  logic                     w_tailOk;
  logic [15:0]              w_hdrLen;
  logic [15:0]              w_hdrSid;
  logic [15:0]              w_rem;
  logic signed [19:0]       w_left;
  logic [c_SID_W-1:0]       w_sidIdx;
  logic [31:0]              w_gap;
  pkt_entry_t               w_entry;
  pkt_entry_t               w_head;

  assign w_accept     = dataIn_val & dataIn_ready;
  assign dataIn_ready = r_readyEn & ~w_full;
  assign w_hdrLen     = {dataIn[23:16], dataIn[31:24]};
  assign w_hdrSid     = {dataIn[7:0], dataIn[15:8]};
  assign w_rem        = r_len - 16'(HDR_BYTES);
  assign w_lenOk      = (r_len >= c_MIN_LEN) && (r_len <= c_MAX_LEN);
  assign w_sidOk      = (r_sid < 16'(NUM_STREAMS));
  assign w_sidIdx     = r_sid[c_SID_W-1:0];
  assign w_gap        = r_seq - r_seqTable[w_sidIdx];
  // Bytes of the remainder still owed when the current data word arrives.
  assign w_left       = $signed({4'd0, r_len}) - $signed(20'd8)
                      - $signed({4'd0, r_wordIdx, 2'b00});
  assign w_tailOk     = (w_left >= 20'sd1) && (w_left <= 20'sd4);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_accept) begin
      case (r_state)
        IDLE:    if (!dataIN_last) w_nextState = HDR2;
        HDR2:    w_nextState = dataIN_last ? IDLE : DATA;
        DATA:    if (dataIN_last) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    w_merged = r_payload;
    for (int b = 0; b < MAX_PAYLOAD; b++) begin
      if (b / 4 == int'(r_wordIdx)) w_merged[8*b +: 8] = dataIn[31 - 8*(b % 4) -: 8];
    end
  end

  // A packet ends on any accepted last beat; ending before DATA is malformed.
  always_comb begin
    w_push         = w_accept & dataIN_last;
    w_bad          = (r_state != DATA) | ~w_lenOk | ~w_tailOk | ~w_sidOk;
    w_entry        = '0;
    w_entry.stream = (r_state == IDLE) ? w_hdrSid : r_sid;
    if (w_bad) begin
      w_entry.payload = '1;
      w_entry.bad     = 1'b1;
    end else begin
      w_entry.payload = w_merged;
      for (int b = 0; b < MAX_PAYLOAD; b++) begin
        if (16'(b) >= w_rem) w_entry.payload[8*b +: 8] = 8'h00;
      end
      w_entry.bytes = w_rem[c_BYTES_W-1:0];
      w_entry.gap   = w_gap;
      w_entry.lost  = |w_gap;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_len     <= '0;
      r_sid     <= '0;
      r_seq     <= '0;
      r_wordIdx <= '0;
      r_payload <= '0;
      r_readyEn <= 1'b0;
      for (int i = 0; i < NUM_STREAMS; i++) r_seqTable[i] <= '0;
    end else begin
      r_readyEn <= 1'b1;
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            r_len     <= w_hdrLen;
            r_sid     <= w_hdrSid;
            r_wordIdx <= '0;
          end
          HDR2: r_seq <= byteSwap(dataIn);
          DATA: begin
            r_payload <= w_merged;
            if (r_wordIdx != '1) r_wordIdx <= r_wordIdx + 1'b1;
          end
          default: ;
        endcase
      end
      if (w_push && !w_bad) r_seqTable[w_sidIdx] <= r_seq + 32'd1;
    end
  end

  assign w_pop = dataOut_ready & ~w_empty;

  parser_out_fifo #(
    .ENTRY_T    (pkt_entry_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_outFifo (
    .clk      (clk),
    .reset_b  (reset_b),
    .push     (w_push),
    .pushData (w_entry),
    .pop      (w_pop),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign dataOut_val = ~w_empty;

  always_comb begin
    dataOut        = '0;
    dataOut_bytes  = '0;
    dataOut_stream = '0;
    dataOut_gap    = '0;
    packetLost     = 1'b0;
    badLength      = 1'b0;
    if (!w_empty) begin
      dataOut        = w_head.payload;
      dataOut_bytes  = w_head.bytes;
      dataOut_stream = w_head.stream;
      dataOut_gap    = w_head.gap;
      packetLost     = w_head.lost;
      badLength      = w_head.bad;
    end
  end

`ifdef PARSER_STATS_EN
  logic [31:0] r_statPkts;
  logic [31:0] r_statLost;
  logic [31:0] r_statBad;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_statPkts <= '0;
      r_statLost <= '0;
      r_statBad  <= '0;
    end else if (w_push) begin
      if (w_bad) begin
        if (r_statBad != '1) r_statBad <= r_statBad + 32'd1;
      end else begin
        if (r_statPkts != '1) r_statPkts <= r_statPkts + 32'd1;
        if ((|w_gap) && (r_statLost != '1)) r_statLost <= r_statLost + 32'd1;
      end
    end
  end

  assign stat_pkts = r_statPkts;
  assign stat_lost = r_statLost;
  assign stat_bad  = r_statBad;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_parser.sv
`default_nettype none
// ============================================================================
// tb_seq_stream_parser: directed and randomized checks of seq_stream_parser
// against a packet-level reference model.                          Rev 1.0
// ============================================================================
module tb_seq_stream_parser;

  localparam int NS   = 32;
  localparam int MAXP = 37;
  localparam int BW   = $clog2(MAXP + 1);
  localparam int PW   = 8 * MAXP;

  typedef struct packed {
    logic [0:PW-1] payload;
    logic [BW-1:0] bytes;
    logic [15:0]   stream;
    logic [31:0]   gap;
    logic          lost;
    logic          bad;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [31:0]   dataIn;
  logic          dataIn_val;
  logic          dataIn_ready;
  logic          dataIN_last;
  logic [0:PW-1] dataOut;
  logic [BW-1:0] dataOut_bytes;
  logic [15:0]   dataOut_stream;
  logic [31:0]   dataOut_gap;
  logic          packetLost;
  logic          badLength;
  logic          dataOut_val;
  logic          dataOut_ready;
`ifdef PARSER_STATS_EN
  logic [31:0]   statPkts, statLost, statBad;
`endif

  int            nCmp = 0;
  int            nBad = 0;
  int            consMode = 0;
  bit            gapMode = 0;
  exp_t          expQ[$];
  exp_t          monE;
  logic [31:0]   tbl [NS];

  always #5 clk = ~clk;

  seq_stream_parser #(.NUM_STREAMS(NS), .MAX_PAYLOAD(MAXP), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .dataIn         (dataIn),
    .dataIn_val     (dataIn_val),
    .dataIn_ready   (dataIn_ready),
    .dataIN_last    (dataIN_last),
    .dataOut        (dataOut),
    .dataOut_bytes  (dataOut_bytes),
    .dataOut_stream (dataOut_stream),
    .dataOut_gap    (dataOut_gap),
    .packetLost     (packetLost),
    .badLength      (badLength),
    .dataOut_val    (dataOut_val),
`ifdef PARSER_STATS_EN
    .stat_pkts      (statPkts),
    .stat_lost      (statLost),
    .stat_bad       (statBad),
`endif
    .dataOut_ready  (dataOut_ready)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    nCmp++;
    nBad++;
    $error("FAIL %s timeout observed=stuck expected=progress", tag);
  endtask

  // Consumer ready: 0 = hold off, 1 = always ready, otherwise random.
  initial begin
    dataOut_ready = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      case (consMode)
        0:       dataOut_ready = 1'b0;
        1:       dataOut_ready = 1'b1;
        default: dataOut_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (dataOut_val && dataOut_ready) begin
      if (expQ.size() == 0) begin
        timeoutFail("unexpected_entry");
      end else begin
        monE = expQ.pop_front();
        chk("payload", dataOut, monE.payload);
        chk("bytes", dataOut_bytes, monE.bytes);
        chk("stream", dataOut_stream, monE.stream);
        chk("gap", dataOut_gap, monE.gap);
        chk("lost", packetLost, monE.lost);
        chk("bad", badLength, monE.bad);
      end
    end else if (!dataOut_val) begin
      chk("empty_outputs_zero",
          {dataOut, dataOut_bytes, dataOut_stream, dataOut_gap, packetLost, badLength}, '0);
    end
  end

  task automatic sendWord(input logic [31:0] w, input logic last);
    int budget;
    if (gapMode && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    dataIn      = w;
    dataIn_val  = 1'b1;
    dataIN_last = last;
    budget      = 0;
    forever begin
      @(negedge clk);
      if (dataIn_ready) break;
      budget++;
      if (budget > 500) begin
        timeoutFail("input_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    dataIn_val  = 1'b0;
    dataIN_last = 1'b0;
  endtask

  // Builds the wire words, predicts the resulting entry from the packet rules, then sends.
  task automatic sendPacket(input logic [15:0] len, input logic [15:0] sid,
                            input logic [31:0] seq, input int nWords, input bit latChk);
    logic [31:0] words[$];
    logic [7:0]  db[$];
    logic [31:0] w;
    exp_t        e;
    int          rem;
    bit          bad;
    words.push_back({len[7:0], len[15:8], sid[7:0], sid[15:8]});
    words.push_back({seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
    for (int i = 2; i < nWords; i++) begin
      w = $urandom;
      words.push_back(w);
      for (int k = 0; k < 4; k++) db.push_back(w[31-8*k -: 8]);
    end
    rem = int'(len) - 8;
    bad = (nWords < 3) || (len < 9) || (int'(len) > MAXP + 8) || (int'(sid) >= NS)
          || ((nWords - 2) != (rem + 3) / 4);
    e = '0;
    e.stream = sid;
    if (bad) begin
      e.payload = '1;
      e.bad     = 1'b1;
    end else begin
      for (int b = 0; b < rem; b++) e.payload[8*b +: 8] = db[b];
      e.bytes = BW'(rem);
      e.gap   = seq - tbl[sid];
      e.lost  = (e.gap != 0);
      tbl[sid] = seq + 32'd1;
    end
    expQ.push_back(e);
    for (int i = 0; i < nWords; i++) sendWord(words[i], i == nWords - 1);
    if (latChk) chk("latency_val", dataOut_val, 1'b1);
  endtask

  task automatic drain();
    int budget = 0;
    while (expQ.size() != 0 && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (expQ.size() != 0) timeoutFail("drain");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] len, sid;
    logic [31:0] seq;
    int          rem, nw;
    for (int i = 0; i < NS; i++) tbl[i] = '0;
    dataIn = '0; dataIn_val = 1'b0; dataIN_last = 1'b0;
    reset_b = 1'b1;
    #2 reset_b = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", dataIn_ready, 1'b0);
    chk("rst_val", dataOut_val, 1'b0);
    chk("rst_data", {dataOut, dataOut_bytes, dataOut_stream, dataOut_gap, packetLost, badLength}, '0);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", dataIn_ready, 1'b1);

    // Full-size in-order packet, then gap detection on the same stream
    consMode = 1;
    sendPacket(16'd45, 16'd3, 32'd0, 12, 1'b1);
    drain();
    sendPacket(16'd13, 16'd3, 32'd1, 4, 1'b1);
    sendPacket(16'd20, 16'd3, 32'd5, 5, 1'b0);
    drain();

    // Malformed packets leave the table alone
    sendPacket(16'd46, 16'd3, 32'd6, 12, 1'b0);
    sendPacket(16'd12, 16'd3, 32'd6, 4, 1'b0);
    sendPacket(16'd13, 16'd4, 32'd0, 1, 1'b0);
    sendPacket(16'd13, 16'd4, 32'd0, 2, 1'b0);
    sendPacket(16'd8, 16'd4, 32'd0, 3, 1'b0);
    sendPacket(16'd12, 16'd3, 32'd6, 3, 1'b0);
    drain();

    // Backpressure with a stalled consumer
    consMode = 0;
    sendPacket(16'd13, 16'd10, 32'd0, 4, 1'b0);
    chk("ready_one_entry", dataIn_ready, 1'b1);
    sendPacket(16'd13, 16'd11, 32'd9, 4, 1'b0);
    chk("ready_full", dataIn_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ready_still_full", dataIn_ready, 1'b0);
    chk("val_while_full", dataOut_val, 1'b1);
    @(negedge clk) consMode = 1;
    @(posedge clk);
    #4 consMode = 0;
    @(posedge clk);
    #4;
    chk("ready_after_pop", dataIn_ready, 1'b1);
    sendPacket(16'd13, 16'd10, 32'd1, 4, 1'b0);
    chk("ready_full_again", dataIn_ready, 1'b0);
    consMode = 1;
    drain();

    // Sequence wrap and out-of-range stream id
    sendPacket(16'd9, 16'd7, 32'hFFFF_FFFF, 3, 1'b0);
    sendPacket(16'd9, 16'd7, 32'h0000_0000, 3, 1'b0);
    sendPacket(16'd13, 16'd40, 32'd0, 4, 1'b0);
    drain();

    // Randomized traffic with idle gaps and a jittery consumer
    consMode = 2;
    gapMode  = 1;
    for (int p = 0; p < 150; p++) begin
      sid = 16'($urandom_range(0, 35));
      if ($urandom_range(0, 9) != 0) len = 16'($urandom_range(9, 45));
      else                           len = 16'($urandom_range(0, 60));
      rem = int'(len) - 8;
      nw  = (rem > 0) ? 2 + (rem + 3) / 4 : 3;
      if ($urandom_range(0, 9) == 0) nw = $urandom_range(1, 14);
      seq = $urandom;
      if ($urandom_range(0, 9) < 7 && int'(sid) < NS) seq = tbl[sid];
      sendPacket(len, sid, seq, nw, 1'b0);
    end
    consMode = 1;
    gapMode  = 0;
    drain();

    // Reset in the middle of a packet
    sendWord({8'd21, 8'd0, 8'd3, 8'd0}, 1'b0);
    sendWord(32'h0700_0000, 1'b0);
    sendWord(32'hDEAD_BEEF, 1'b0);
    reset_b = 1'b0;
    #1;
    chk("midrst_ready", dataIn_ready, 1'b0);
    chk("midrst_val", dataOut_val, 1'b0);
    for (int i = 0; i < NS; i++) tbl[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_release", dataIn_ready, 1'b1);
    sendPacket(16'd13, 16'd3, 32'd0, 4, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("final_empty", dataOut_val, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
